muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It executes the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations that the ALU control decodes. Products and quotients take several cycles, so the unit holds oBusy to stall the pipeline and pulses oDone when HI/LO hold the new result. HI/LO are always readable for MFHI/MFLO.

## Interface
- WIDTH, 32: operand width; HI and LO are WIDTH bits each; must be at least 4 and even.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset; synchronous, active-high.
- iStart  in  1  request; sampled only when oBusy=0.
- iOp  in  3  operation: NONE=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MTLO=110; 111 is treated as NONE.
- iA  in  WIDTH  rs operand (multiplicand / dividend / MTxx source).
- iB  in  WIDTH  rt operand (multiplier / divisor).
- oHI  out  WIDTH  HI register; reset value 0.
- oLO  out  WIDTH  LO register; reset value 0.
- oBusy  out  1  multi-cycle operation in progress; reset value 0.
- oDone  out  1  one-cycle pulse after a MULT/DIV result is written; reset value 0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - iStart with MTHI writes HI<=iA at that edge. iStart with MTLO writes LO<=iA. Neither changes state, asserts oBusy or pulses oDone.
  - iStart with MULT/MULTU/DIV/DIVU: latch the operation, latch |iA| and |iB| (raw values for unsigned ops), latch the result sign(s), clear the count, go to RUN.
  - iStart with NONE/111: no effect.
- RUN: exactly WIDTH iterations, one per cycle, then go to FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply sign correction and write HI/LO at the edge leaving FIX, then return to IDLE.
  - MULT: negate the 2·WIDTH product if the operand signs differ. HI = upper half, LO = lower half.
  - DIV: quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - All divides: LO = quotient, HI = remainder.
- Divide by zero (iB=0), both DIV and DIVU: LO = all ones, HI = iA unchanged. The unit still takes full latency.
- Signed overflow (iA = most-negative, iB = −1): LO = most-negative, HI = 0. This follows from two's-complement wrap; no trap.
- iStart while oBusy=1 is ignored entirely, including MTHI/MTLO. The requester must hold the request until oBusy=0.
- HI/LO are never partially updated; they change only at the FIX exit or on an MTxx edge.

## Timing
- Start accepted at edge E0.
- oBusy=1 from after E0 through the cycle before edge E(WIDTH+2).
- HI/LO take the new values at E(WIDTH+2). oBusy falls at the same edge. oDone=1 for exactly the cycle after E(WIDTH+2).
- Total latency: WIDTH+2 cycles from the accepting edge to valid HI/LO (34 for WIDTH=32).
- A new iStart may be accepted in the same cycle oDone is high.
- MTHI/MTLO take effect at the accepting edge (0-cycle latency as seen at the next cycle's outputs).
- iRST=1 at any edge: state→IDLE, HI=LO=0, oBusy=0, oDone=0, and any in-flight operation is discarded. Reset takes priority over iStart.

## Structure
- Shared package `muldiv_pkg` holds:
  - the iOp encodings (OP_NONE…OP_MTLO);
  - the state enum (ST_IDLE, ST_RUN, ST_FIX);
  - the count width, $clog2(WIDTH+1).
- The ALU control decoder maps funct codes to these iOp values through the same package.
- One sub-module, `muldiv_signfix`, is natural: the combinational abs/negate logic used both at operand latch and in FIX, parametrised by WIDTH.
- The FSM, iteration datapath and HI/LO registers live in `muldiv_unit`.

## Test plan
- MULT iA=0xFFFFFFFD (−3), iB=5 → at cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFF1. oDone is a single pulse; oBusy is high for 34 cycles.
- DIVU iA=100, iB=7 → LO=14, HI=2. Then DIV iA=0xFFFFFFF9 (−7), iB=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV iA=0x80000000, iB=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU iA=0x1234, iB=0 → LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xA5A5A5A5 while idle → HI updated next cycle with no oBusy. MTLO issued while busy → ignored, and LO equals the MULT result afterwards.
- MULTU 0xFFFFFFFF×0xFFFFFFFF started back-to-back with the cycle oDone is high → HI=0xFFFFFFFE, LO=1. The second operation completes 34 cycles later.
- iRST asserted at cycle 10 of a MULT → the next cycle shows oBusy=0, HI=LO=0, and no oDone pulse. Repeat the whole suite at WIDTH=8.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit and the ALU control
// decoder that drives it: operation encodings for iOp, the unit's state
// encoding, and the iteration-counter width as a function of the operand width.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111   // decoded as OP_NONE
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // The counter must hold the value WIDTH itself (terminal count).
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Conditional two's-complement negation. Used to take |x| of signed operands
// when a multiply/divide is accepted, and to restore the result sign before
// HI/LO are written.
//   val_i : WIDTH-bit input value
//   neg_i : 1 = output the two's-complement negation of val_i
//   res_o : WIDTH-bit result
// -----------------------------------------------------------------------------
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] res_o
);

   logic [WIDTH-1:0] neg_val;

   // Negating the most-negative value wraps back to itself; treated as unsigned
   // magnitude this is exactly 2^(WIDTH-1), which is what the datapath needs.
   assign neg_val = (~val_i) + WIDTH'(1);
   assign res_o   = neg_i ? neg_val : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per cycle
// on operand magnitudes; signs are restored in a final FIX cycle. MTHI/MTLO
// write HI/LO directly when the unit is idle.
//   iCLK   : clock, rising edge
//   iRST   : synchronous active-high reset
//   iStart : request, sampled only while oBusy = 0
//   iOp    : operation (muldiv_pkg::op_e encoding)
//   iA     : rs operand (multiplicand / dividend / MTxx source)
//   iB     : rt operand (multiplier / divisor)
//   oHI    : HI register
//   oLO    : LO register
//   oBusy  : multi-cycle operation in flight
//   oDone  : one-cycle pulse after a MULT/DIV result lands in HI/LO
// Latency from the accepting edge to valid HI/LO is WIDTH+2 edges.
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [2:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic [WIDTH-1:0] oHI,
   output logic [WIDTH-1:0] oLO,
   output logic             oBusy,
   output logic             oDone
);

   localparam int CNT_W = cnt_width(WIDTH);

   // control state (reset)
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   // datapath state (latched at start, no reset needed)
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic               div_q;
   logic               negq_q;   // negate product / quotient
   logic               negr_q;   // negate remainder

   op_e                op_in;
   logic               is_signed_in, is_div_in, is_arith_in;
   logic               start_arith;
   logic               b_zero;
   logic [WIDTH-1:0]   abs_a, abs_b;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign op_in        = op_e'(iOp);
   assign is_signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
   assign is_div_in    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
   assign is_arith_in  = is_div_in || (op_in == OP_MULT) || (op_in == OP_MULTU);
   assign start_arith  = iStart && (state_q == ST_IDLE) && is_arith_in;
   assign b_zero       = (iB == '0);

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
      .val_i (iA),
      .neg_i (is_signed_in & iA[WIDTH-1]),
      .res_o (abs_a)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
      .val_i (iB),
      .neg_i (is_signed_in & iB[WIDTH-1]),
      .res_o (abs_b)
   );

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   // Add the multiplicand into the upper half when the multiplier LSB is set,
   // then shift the whole accumulator right, keeping the carry.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring divide step: acc = {remainder, dividend/quotient}. Shift the
   // next dividend bit into the remainder and trial-subtract the divisor; a
   // borrow means the subtraction is discarded and the quotient bit is 0.
   // A zero divisor always succeeds, giving all-ones quotient and the dividend
   // as remainder.
   assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
   assign div_next  = div_trial[WIDTH]
                    ? {acc_q[2*WIDTH-2:0], 1'b0}
                    : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .val_i (acc_q),
      .neg_i (negq_q),
      .res_o (prod_fix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
      .val_i (acc_q[WIDTH-1:0]),
      .neg_i (negq_q),
      .res_o (quo_fix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
      .val_i (acc_q[2*WIDTH-1:WIDTH]),
      .neg_i (negr_q),
      .res_o (rem_fix)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = (state_q == ST_FIX);

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               case (op_in)
                  OP_MTHI: hi_d = iA;
                  OP_MTLO: lo_d = iA;
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d = ST_RUN;
                     cnt_d   = '0;
                     acc_d   = is_div_in ? {{WIDTH{1'b0}}, abs_a}
                                         : {{WIDTH{1'b0}}, abs_b};
                  end
                  default: ;
               endcase
            end
         end

         ST_RUN: begin
            // WIDTH iterations, then one settling cycle at terminal count
            // before FIX; this fixes the latency at WIDTH+2.
            if (cnt_q == CNT_W'(WIDTH)) begin
               state_d = ST_FIX;
            end else begin
               acc_d = div_q ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            if (div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge iCLK) begin
      acc_q <= acc_d;
      if (start_arith) begin
         opnd_q <= is_div_in ? abs_b : abs_a;
         div_q  <= is_div_in;
         // A zero divisor must leave the quotient at all ones, so no negation.
         negq_q <= is_signed_in & (iA[WIDTH-1] ^ iB[WIDTH-1]) & ~(is_div_in & b_zero);
         negr_q <= is_signed_in & iA[WIDTH-1];
      end
   end

   assign oHI   = hi_q;
   assign oLO   = lo_q;
   assign oBusy = (state_q != ST_IDLE);
   assign oDone = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32, st32, busy32, done32;
   logic [2:0]  op32;
   logic [31:0] a32, b32, hi32, lo32;

   logic        rst8, st8, busy8, done8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, hi8, lo8;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(32)) u_dut32 (
      .iCLK(clk), .iRST(rst32), .iStart(st32), .iOp(op32), .iA(a32), .iB(b32),
      .oHI(hi32), .oLO(lo32), .oBusy(busy32), .oDone(done32)
   );

   muldiv_unit #(.WIDTH(8)) u_dut8 (
      .iCLK(clk), .iRST(rst8), .iStart(st8), .iOp(op8), .iA(a8), .iB(b8),
      .oHI(hi8), .oLO(lo8), .oBusy(busy8), .oDone(done8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (s == 0) begin
         st32 = st; op32 = op; a32 = a; b32 = b;
      end else begin
         st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      end
   endtask

   task automatic set_rst(input int s, input logic v);
      if (s == 0) rst32 = v;
      else        rst8  = v;
   endtask

   function automatic logic [31:0] hi_of(input int s);
      return (s == 0) ? hi32 : {24'h0, hi8};
   endfunction
   function automatic logic [31:0] lo_of(input int s);
      return (s == 0) ? lo32 : {24'h0, lo8};
   endfunction
   function automatic logic busy_of(input int s);
      return (s == 0) ? busy32 : busy8;
   endfunction
   function automatic logic done_of(input int s);
      return (s == 0) ? done32 : done8;
   endfunction
   function automatic logic [31:0] sel(input int s, input logic [31:0] v32, input logic [31:0] v8);
      return (s == 0) ? v32 : v8;
   endfunction

   // Issue one multi-cycle op and check latency, done pulse and result.
   // Returns in the cycle oDone is high, so a following call starts back-to-back.
   task automatic do_op(input int s, input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      int n = 0;
      int early = 0;
      int w = (s == 0) ? 32 : 8;
      drive(s, 1'b1, op, a, b);
      tick();
      drive(s, 1'b0, OP_NONE, 0, 0);
      check({tag, "_busy"}, busy_of(s), 1);
      while (busy_of(s) && n < 200) begin
         if (done_of(s)) early++;
         tick();
         n++;
      end
      check({tag, "_latency"}, n, w + 2);
      check({tag, "_early_done"}, early, 0);
      check({tag, "_done"}, done_of(s), 1);
      check({tag, "_hi"}, hi_of(s), eh);
      check({tag, "_lo"}, lo_of(s), el);
   endtask

   task automatic run_suite(input int s);
      string p;
      int n;
      p = (s == 0) ? "w32" : "w8";

      set_rst(s, 1'b1);
      drive(s, 1'b0, OP_NONE, 0, 0);
      tick(); tick();
      set_rst(s, 1'b0);
      check({p, "_rst_hi"},   hi_of(s), 0);
      check({p, "_rst_lo"},   lo_of(s), 0);
      check({p, "_rst_busy"}, busy_of(s), 0);
      check({p, "_rst_done"}, done_of(s), 0);

      do_op(s, {p, "_mult"}, OP_MULT, sel(s, 32'hFFFFFFFD, 32'hFD), 5,
            sel(s, 32'hFFFFFFFF, 32'hFF), sel(s, 32'hFFFFFFF1, 32'hF1));
      tick();
      check({p, "_mult_done_pulse"}, done_of(s), 0);

      do_op(s, {p, "_divu"}, OP_DIVU, 100, 7, 2, 14);
      tick();
      do_op(s, {p, "_div_neg"}, OP_DIV, sel(s, 32'hFFFFFFF9, 32'hF9), 2,
            sel(s, 32'hFFFFFFFF, 32'hFF), sel(s, 32'hFFFFFFFD, 32'hFD));
      tick();
      do_op(s, {p, "_div_ovf"}, OP_DIV, sel(s, 32'h80000000, 32'h80), sel(s, 32'hFFFFFFFF, 32'hFF),
            0, sel(s, 32'h80000000, 32'h80));
      tick();
      do_op(s, {p, "_divu_zero"}, OP_DIVU, sel(s, 32'h1234, 32'h34), 0,
            sel(s, 32'h1234, 32'h34), sel(s, 32'hFFFFFFFF, 32'hFF));
      // started in the cycle oDone is high
      do_op(s, {p, "_multu_b2b"}, OP_MULTU, sel(s, 32'hFFFFFFFF, 32'hFF), sel(s, 32'hFFFFFFFF, 32'hFF),
            sel(s, 32'hFFFFFFFE, 32'hFE), 1);
      tick();

      drive(s, 1'b1, OP_MTHI, sel(s, 32'hA5A5A5A5, 32'hA5), 0);
      tick();
      drive(s, 1'b0, OP_NONE, 0, 0);
      check({p, "_mthi_hi"},   hi_of(s), sel(s, 32'hA5A5A5A5, 32'hA5));
      check({p, "_mthi_lo"},   lo_of(s), 1);
      check({p, "_mthi_busy"}, busy_of(s), 0);
      check({p, "_mthi_done"}, done_of(s), 0);

      drive(s, 1'b1, OP_MULT, sel(s, 32'hFFFFFFFD, 32'hFD), 5);
      tick();
      drive(s, 1'b1, OP_MTLO, sel(s, 32'h5A5A5A5A, 32'h5A), 0);
      tick(); tick(); tick();
      drive(s, 1'b0, OP_NONE, 0, 0);
      check({p, "_mtlo_busy_lo_hold"}, lo_of(s), 1);
      n = 0;
      while (busy_of(s) && n < 200) begin
         tick();
         n++;
      end
      check({p, "_mtlo_busy_wait"}, busy_of(s), 0);
      check({p, "_mtlo_busy_lo"}, lo_of(s), sel(s, 32'hFFFFFFF1, 32'hF1));
      check({p, "_mtlo_busy_hi"}, hi_of(s), sel(s, 32'hFFFFFFFF, 32'hFF));
      tick();

      drive(s, 1'b1, OP_MULT, 7, 9);
      tick();
      drive(s, 1'b0, OP_NONE, 0, 0);
      repeat (9) tick();
      check({p, "_rstmid_busy_before"}, busy_of(s), 1);
      set_rst(s, 1'b1);
      tick();
      set_rst(s, 1'b0);
      check({p, "_rstmid_busy"}, busy_of(s), 0);
      check({p, "_rstmid_hi"},   hi_of(s), 0);
      check({p, "_rstmid_lo"},   lo_of(s), 0);
      check({p, "_rstmid_done"}, done_of(s), 0);
      n = 0;
      repeat (40) begin
         tick();
         if (done_of(s) || busy_of(s)) n++;
      end
      check({p, "_rstmid_quiet"}, n, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst32 = 1'b1; rst8 = 1'b1;
      drive(0, 1'b0, OP_NONE, 0, 0);
      drive(1, 1'b0, OP_NONE, 0, 0);
      tick();
      run_suite(0);
      run_suite(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
